// File: rtl/controle_mais_menos.sv
// controle_mais_menos: sequencing controller for the 2-bit up/down level counter.
// Turns held button levels into single-cycle count commands, flags saturation,
// and locks the chosen level on confirmation.
// Optional feature macro: CONTROLE_AUTO_REPEAT_EN (auto-repeat while a single
// button is held; when undefined SEGURA only waits for release).
module controle_mais_menos #(
  parameter int HOLD_CYCLES   = 50,
  parameter int REPEAT_CYCLES = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ativo,
  input  logic       btn_mais,
  input  logic       btn_menos,
  input  logic       confirma,
  input  logic [1:0] nivel,
  output logic       conta_enable,
  output logic       conta_mais,
  output logic       conta_menos,
  output logic       limite,
  output logic       pronto,
  output logic [1:0] nivel_escolhido
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] ESPERA  = 2'd1;
  localparam logic [1:0] SEGURA  = 2'd2;
  localparam logic [1:0] TRAVADO = 2'd3;

  // Parameter sanity: a repeat must leave room for the counter update, and the
  // repeat interval must fit in the hold counter.
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > HOLD_CYCLES || HOLD_CYCLES < 1) begin : g_param_invalido
    $error("controle_mais_menos: requires 2 <= REPEAT_CYCLES <= HOLD_CYCLES");
  end

  logic [1:0] estado_reg, estado_next;
  logic       enable_next, mais_next, menos_next, limite_next, pronto_next;
  logic [1:0] escolhido_next;
  logic       pede_mais, pede_menos;
  logic       so_mais, so_menos;

  assign so_mais  = btn_mais & ~btn_menos;
  assign so_menos = btn_menos & ~btn_mais;

`ifdef CONTROLE_AUTO_REPEAT_EN
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          repetindo_reg, repetindo_next;
  logic [1:0]    lado_reg, lado_next;
  logic [CW-1:0] limiar;
  logic          dispara;

  assign limiar = repetindo_reg ? CW'(REPEAT_CYCLES) : CW'(HOLD_CYCLES);

  // Hold timing: counts edges since the last pulse (or since the held button changed).
  always_comb begin
    cnt_next       = cnt_reg;
    repetindo_next = repetindo_reg;
    lado_next      = lado_reg;
    dispara        = 1'b0;
    if (estado_reg == ESPERA && ativo && (btn_mais || btn_menos)) begin
      // First press: this edge is offset 0 of the hold measurement.
      cnt_next       = CW'(1);
      repetindo_next = 1'b0;
      lado_next      = {so_mais, so_menos};
    end else if (estado_reg == SEGURA && ativo) begin
      if (so_mais || so_menos) begin
        if ({so_mais, so_menos} != lado_reg) begin
          // Different button now held: restart the hold measurement.
          cnt_next       = CW'(1);
          repetindo_next = 1'b0;
          lado_next      = {so_mais, so_menos};
        end else if (cnt_reg >= limiar) begin
          dispara        = 1'b1;
          cnt_next       = CW'(1);
          repetindo_next = 1'b1;
        end else if (cnt_reg != {CW{1'b1}}) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end else if (btn_mais && btn_menos) begin
        // Both held: no single direction, any later single press restarts.
        lado_next = 2'b00;
      end
    end
  end

  // Hold-timing state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg       <= '0;
      repetindo_reg <= 1'b0;
      lado_reg      <= 2'b00;
    end else begin
      cnt_reg       <= cnt_next;
      repetindo_reg <= repetindo_next;
      lado_reg      <= lado_next;
    end
  end
`endif

  // Next-state and command decision; pulses are requested here and then
  // filtered by the saturation check below.
  always_comb begin
    estado_next    = estado_reg;
    pede_mais      = 1'b0;
    pede_menos     = 1'b0;
    escolhido_next = nivel_escolhido;
    if (!ativo) begin
      estado_next = OCIOSO;
    end else begin
      case (estado_reg)
        OCIOSO: estado_next = ESPERA;
        ESPERA: begin
          if (btn_mais && btn_menos) begin
            estado_next = SEGURA;
          end else if (so_mais) begin
            pede_mais   = 1'b1;
            estado_next = SEGURA;
          end else if (so_menos) begin
            pede_menos  = 1'b1;
            estado_next = SEGURA;
          end else if (confirma) begin
            escolhido_next = nivel;
            estado_next    = TRAVADO;
          end
        end
        SEGURA: begin
          if (!btn_mais && !btn_menos) begin
            estado_next = ESPERA;
          end else begin
`ifdef CONTROLE_AUTO_REPEAT_EN
            pede_mais  = dispara & so_mais;
            pede_menos = dispara & so_menos;
`endif
          end
        end
        default: estado_next = TRAVADO;
      endcase
    end
  end

  // Saturation: a request at the counter limit becomes a limite flag instead.
  always_comb begin
    enable_next = 1'b0;
    mais_next   = 1'b0;
    menos_next  = 1'b0;
    limite_next = 1'b0;
    if (pede_mais) begin
      if (nivel != 2'd3) begin
        enable_next = 1'b1;
        mais_next   = 1'b1;
      end else begin
        limite_next = 1'b1;
      end
    end else if (pede_menos) begin
      if (nivel != 2'd0) begin
        enable_next = 1'b1;
        menos_next  = 1'b1;
      end else begin
        limite_next = 1'b1;
      end
    end
    pronto_next = (estado_next == TRAVADO);
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg      <= OCIOSO;
      conta_enable    <= 1'b0;
      conta_mais      <= 1'b0;
      conta_menos     <= 1'b0;
      limite          <= 1'b0;
      pronto          <= 1'b0;
      nivel_escolhido <= 2'd0;
    end else begin
      estado_reg      <= estado_next;
      conta_enable    <= enable_next;
      conta_mais      <= mais_next;
      conta_menos     <= menos_next;
      limite          <= limite_next;
      pronto          <= pronto_next;
      nivel_escolhido <= escolhido_next;
    end
  end

endmodule

// File: tb/tb_controle_mais_menos.sv
// Testbench for controle_mais_menos: scoreboard of expected pulse/limite events
// checked by a negedge monitor, plus direct checks of pronto/nivel_escolhido/reset.
module tb_controle_mais_menos;

  localparam int HOLD = 5;
  localparam int REP  = 3;

  localparam logic [3:0] EV_MAIS  = 4'b1100; // {enable, mais, menos, limite}
  localparam logic [3:0] EV_MENOS = 4'b1010;
  localparam logic [3:0] EV_LIM   = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ativo = 1'b0;
  logic       btn_mais = 1'b0;
  logic       btn_menos = 1'b0;
  logic       confirma = 1'b0;
  logic [1:0] nivel;
  logic       conta_enable, conta_mais, conta_menos, limite, pronto;
  logic [1:0] nivel_escolhido;

  logic       carregar = 1'b0;
  logic [1:0] valor = 2'd0;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t fila[$];
  ev_t e;

  controle_mais_menos #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clock(clock), .reset(reset), .ativo(ativo),
    .btn_mais(btn_mais), .btn_menos(btn_menos), .confirma(confirma),
    .nivel(nivel), .conta_enable(conta_enable), .conta_mais(conta_mais),
    .conta_menos(conta_menos), .limite(limite), .pronto(pronto),
    .nivel_escolhido(nivel_escolhido)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // External 2-bit up/down counter, with a load port for placing the level.
  always @(posedge clock or posedge reset) begin
    if (reset) nivel <= 2'd0;
    else if (carregar) nivel <= valor;
    else if (conta_enable) nivel <= conta_mais ? nivel + 2'd1 : nivel - 2'd1;
  end

  // Monitor: every observed pulse/limite must match the next queued expectation.
  always @(negedge clock) begin
    if (conta_enable || conta_mais || conta_menos || limite) begin
      checks++;
      if (fila.size() == 0) begin
        errors++;
        $display("FAIL evento_inesperado cyc=%0d got=%b required none", cyc,
                 {conta_enable, conta_mais, conta_menos, limite});
      end else begin
        e = fila.pop_front();
        if (e.cyc != cyc || e.kind != {conta_enable, conta_mais, conta_menos, limite}) begin
          errors++;
          $display("FAIL evento cyc=%0d got=%b required cyc=%0d kind=%b", cyc,
                   {conta_enable, conta_mais, conta_menos, limite}, e.cyc, e.kind);
        end else begin
          $display("evento ok cyc=%0d kind=%b", cyc, e.kind);
        end
      end
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic carrega(input logic [1:0] v);
    valor    = v;
    carregar = 1'b1;
    @(negedge clock);
    carregar = 1'b0;
  endtask

  task automatic espera_ev(input int offset, input logic [3:0] kind);
    fila.push_back('{cyc + offset, kind});
  endtask

  task automatic verifica(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", nome, got, exp);
    end else begin
      $display("check ok %s = %0d", nome, got);
    end
  endtask

  initial begin
    ciclos(3);
    reset = 1'b0;
    verifica("reset_enable", 32'(conta_enable), 0);
    verifica("reset_limite", 32'(limite), 0);
    verifica("reset_pronto", 32'(pronto), 0);
    verifica("reset_escolhido", 32'(nivel_escolhido), 0);

    ativo = 1'b1;
    ciclos(2);
    carrega(2'd0);

    // Single press held 2 cycles: one increment pulse, 1 cycle after the press edge.
    btn_mais = 1'b1; espera_ev(1, EV_MAIS);
    ciclos(2); btn_mais = 1'b0; ciclos(3);

    // Saturation at the top.
    carrega(2'd3);
    btn_mais = 1'b1; espera_ev(1, EV_LIM);
    ciclos(1); btn_mais = 1'b0; ciclos(2);

    // Saturation at the bottom.
    carrega(2'd0);
    btn_menos = 1'b1; espera_ev(1, EV_LIM);
    ciclos(1); btn_menos = 1'b0; ciclos(2);

    // Both buttons: nothing; then a single decrement works normally.
    carrega(2'd2);
    btn_mais = 1'b1; btn_menos = 1'b1;
    ciclos(3); btn_mais = 1'b0; btn_menos = 1'b0; ciclos(2);
    btn_menos = 1'b1; espera_ev(1, EV_MENOS);
    ciclos(1); btn_menos = 1'b0; ciclos(2);

    // Long hold from level 0 for 12 cycles.
    carrega(2'd0);
    btn_mais = 1'b1; espera_ev(1, EV_MAIS);
`ifdef CONTROLE_AUTO_REPEAT_EN
    espera_ev(1 + HOLD, EV_MAIS);
    espera_ev(1 + HOLD + REP, EV_MAIS);
    espera_ev(1 + HOLD + 2 * REP, EV_LIM);
`endif
    ciclos(12); btn_mais = 1'b0; ciclos(2);

    // Confirmation locks the level; buttons ignored; ativo=0 unlocks.
    carrega(2'd2);
    verifica("pronto_antes", 32'(pronto), 0);
    confirma = 1'b1; ciclos(1); confirma = 1'b0;
    verifica("pronto_confirma", 32'(pronto), 1);
    verifica("escolhido_confirma", 32'(nivel_escolhido), 2);
    btn_mais = 1'b1; ciclos(2); btn_mais = 1'b0;
    btn_menos = 1'b1; ciclos(2); btn_menos = 1'b0;
    verifica("pronto_travado", 32'(pronto), 1);
    ativo = 1'b0; ciclos(1);
    verifica("pronto_desativa", 32'(pronto), 0);
    verifica("escolhido_retido", 32'(nivel_escolhido), 2);

    // Asynchronous reset in the middle of a pulse.
    ativo = 1'b1; ciclos(2);
    carrega(2'd0);
    btn_mais = 1'b1;
    @(posedge clock); #1;
    verifica("pulso_antes_reset", 32'({conta_enable, conta_mais}), 3);
    reset = 1'b1; #1;
    verifica("reset_pulso_enable", 32'({conta_enable, conta_mais, conta_menos, limite}), 0);
    verifica("reset_pulso_pronto", 32'(pronto), 0);
    verifica("reset_pulso_escolhido", 32'(nivel_escolhido), 0);
    @(negedge clock);
    btn_mais = 1'b0; confirma = 1'b1; reset = 1'b0;
    ciclos(1);
    verifica("pronto_pos_reset_ocioso", 32'(pronto), 0);
    ciclos(1);
    verifica("pronto_pos_reset_espera", 32'(pronto), 1);
    confirma = 1'b0;
    ciclos(2);

    checks++;
    if (fila.size() != 0) begin
      errors++;
      $display("FAIL eventos_pendentes got=%0d required=0", fila.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_mais_menos.md
# controle_mais_menos

Sequencing controller for the 2-bit up/down level counter. Converts held push-button levels into single-cycle count commands (`conta_enable`, `conta_mais`, `conta_menos`) that drive the counter's `enable`/`mais`/`menos` inputs, and reads the counter value back. It optionally auto-repeats while a button is held, and latches the chosen level on confirmation. It sits between the synchronized button inputs and the counter inside the project's level-selection datapath.

## Interface
- `HOLD_CYCLES`, 50: cycles a button must stay held before the first auto-repeat pulse.
- `REPEAT_CYCLES`, 10: cycles between subsequent auto-repeat pulses.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `ativo`  in  1  controller enable; low forces the controller idle.
- `btn_mais`  in  1  increment button; synchronized level.
- `btn_menos`  in  1  decrement button; synchronized level.
- `confirma`  in  1  confirm the current level; synchronized level.
- `nivel`  in  2  counter Q feedback.
- `conta_enable`  out  1  one-cycle counter enable pulse.
- `conta_mais`  out  1  one-cycle increment; always concurrent with `conta_enable`.
- `conta_menos`  out  1  one-cycle decrement; always concurrent with `conta_enable`.
- `limite`  out  1  one-cycle flag: a request was blocked by saturation.
- `pronto`  out  1  high while the level is locked.
- `nivel_escolhido`  out  2  level captured at confirmation.

## Operation
- States are OCIOSO, ESPERA, SEGURA and TRAVADO.
- All outputs are registered. Reset value of every output is 0, and the state resets to OCIOSO.
- OCIOSO:
  - Goes to ESPERA when `ativo`=1.
  - `pronto`=0.
- ESPERA: evaluate the inputs in this priority order.
  - Both buttons high: no pulse; go to SEGURA (wait for release).
  - `btn_mais` only, `nivel`<3: issue `conta_enable`+`conta_mais`; go to SEGURA.
  - `btn_mais` only, `nivel`=3: no count pulse; issue `limite`; go to SEGURA.
  - `btn_menos` only: symmetric, with the saturation check at `nivel`=0.
  - `confirma` with no button held: capture `nivel_escolhido`<=`nivel`, set `pronto`=1, go to TRAVADO.
- SEGURA:
  - Return to ESPERA when both buttons are low.
  - With AUTO_REPEAT_EN and exactly one button held, apply the repeat timing in Timing.
  - A repeat pulse obeys the same saturation and `limite` rules as the first pulse.
  - A change of which button is held restarts the hold count.
  - `confirma` is ignored.
- TRAVADO:
  - All buttons ignored; `pronto` stays 1.
  - `ativo`=0 goes to OCIOSO and clears `pronto`. `nivel_escolhido` is retained.
- `ativo`=0 in any state gives OCIOSO on the next edge. No pulse is issued on that edge.
- At most one of `conta_mais`/`conta_menos` is ever high. Both are 0 whenever `conta_enable`=0.
- Hold counter width is $clog2(HOLD_CYCLES+1). It saturates and never wraps.

## Timing
- Press latency: button high at edge k in ESPERA gives the pulse high in cycle k→k+1. The counter updates at edge k+1, and the new `nivel` is visible after edge k+1.
- Each pulse is exactly one cycle wide. There is one pulse per press without AUTO_REPEAT_EN.
- Auto-repeat (AUTO_REPEAT_EN): measured from the first pulse, the first repeat pulse comes HOLD_CYCLES cycles later. Each further repeat comes every REPEAT_CYCLES cycles.
- The saturation check uses the `nivel` sampled at the same edge as the decision. The 1-cycle counter update is always complete before the next decision, since REPEAT_CYCLES≥2 is required.
- `confirma` to `pronto`: `confirma` high at edge k gives `pronto`=1 after edge k.
- Asynchronous reset mid-pulse clears the pulse immediately.

## Configuration
- `CONTROLE_AUTO_REPEAT_EN`:
  - Defined: auto-repeat while a single button is held, per the Timing rules.
  - Undefined: SEGURA only waits for release. The hold counter and parameters are unused and optimized away.

## Test plan
- Reset, `ativo`=1, `nivel`=0: press `btn_mais` 2 cycles then release → exactly one `conta_enable`+`conta_mais` pulse, 1 cycle after the press edge.
- `nivel`=3, press `btn_mais` → no count pulse, `limite`=1 for one cycle. `nivel`=0 with `btn_menos` → same behaviour.
- Both buttons pressed together → no pulses; a single button pressed after releasing both → a normal pulse.
- With macro, HOLD_CYCLES=5, REPEAT_CYCLES=3: hold `btn_mais` 12 cycles starting at `nivel`=0 → pulses at offsets 0, 5, 8; the next decision (offset 11) sees `nivel`=3 and gives `limite`. Without macro → a single pulse.
- `nivel`=2, `confirma` → `pronto`=1, `nivel_escolhido`=2, buttons ignored; `ativo`=0 → OCIOSO, `pronto`=0.
- Assert `reset` during a pulse cycle → all outputs 0 immediately, state OCIOSO.
